// File: rtl/uart_tx_datapath_if.sv
// ---------------------------------------------------------------------------
// uart_tx_datapath_if
// Bundles the signals between the UART TX control FSM (master) and the
// transmit datapath (slave).
//
//   P_DATA     master->slave  parallel byte to transmit
//   Data_Valid master->slave  P_DATA valid this cycle
//   PAR_TYP    master->slave  parity type, 0 = even, 1 = odd
//   busy       master->slave  FSM in START/SERIALIZATION/PARITY/STOP
//   ser_en     master->slave  FSM in SERIALIZATION
//   mux_sel    master->slave  00 start, 10 data, 11 parity, 01 stop
//   ser_done   slave->master  last data bit selected this cycle (comb)
//   TX_OUT     slave->master  registered serial line
//
// Handshake: there is no ready. A byte is accepted on any cycle where
// Data_Valid is high and the FSM is idle or in STOP; otherwise the
// Data_Valid is dropped without effect.
// ---------------------------------------------------------------------------
interface uart_tx_datapath_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_TYP;
    logic                  busy;
    logic                  ser_en;
    logic [1:0]            mux_sel;
    logic                  ser_done;
    logic                  TX_OUT;

    modport master (
        output P_DATA, Data_Valid, PAR_TYP, busy, ser_en, mux_sel,
        input  ser_done, TX_OUT
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_TYP, busy, ser_en, mux_sel,
        output ser_done, TX_OUT
    );
endinterface

// File: rtl/uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// uart_tx_datapath
// Transmit datapath of the UART TX path. Latches the parallel byte, computes
// its parity, shifts it out LSB-first under ser_en, flags the last data bit
// with ser_done and drives the registered serial line TX_OUT.
//
// Ports:
//   CLK  bit clock (one cycle per bit period)
//   RST  asynchronous active-low reset
//   bus  uart_tx_datapath_if.slave (see interface for signal list)
//
// DATA_WIDTH must be 2 or more.
// ---------------------------------------------------------------------------
module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_datapath_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  par;
    logic                  tx_q;
    logic                  tx_nxt;
    logic                  load;
    logic                  done;

    // Loading in STOP lets the next start bit follow the stop bit directly.
    assign load = bus.Data_Valid & (~bus.busy | (bus.mux_sel == 2'b01));
    assign done = bus.ser_en & (cnt == CNT_LAST);

    assign bus.ser_done = done;
    assign bus.TX_OUT   = tx_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
            par   <= 1'b0;
        end else if (load) begin
            shreg <= bus.P_DATA;
            cnt   <= '0;
            par   <= (^bus.P_DATA) ^ bus.PAR_TYP;
        end else if (bus.ser_en) begin
            shreg <= shreg >> 1;
            cnt   <= done ? '0 : cnt + CW'(1);
        end
    end

    // Line level for the next bit; shreg[0] is taken before this edge's shift.
    always_comb begin
        tx_nxt = 1'b1;
        if (bus.busy) begin
            case (bus.mux_sel)
                2'b00:   tx_nxt = 1'b0;
                2'b10:   tx_nxt = shreg[0];
                2'b11:   tx_nxt = par;
                default: tx_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) tx_q <= 1'b1;
        else      tx_q <= tx_nxt;
    end
endmodule

// File: tb/tb_uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_datapath
// Directed bench for uart_tx_datapath. A width-8 and a width-5 instance share
// clock and reset; the bench plays the FSM role, driving inputs on the
// falling edge and sampling TX_OUT on the following falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_datapath;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    uart_tx_datapath_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_datapath_if #(.DATA_WIDTH(5)) if5 ();

    uart_tx_datapath #(.DATA_WIDTH(8)) dut8 (.CLK(clk), .RST(rst_n), .bus(if8));
    uart_tx_datapath #(.DATA_WIDTH(5)) dut5 (.CLK(clk), .RST(rst_n), .bus(if5));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic set_in(input int sel, input logic dv, input logic [7:0] d,
                          input logic pt, input logic b, input logic se,
                          input logic [1:0] ms);
        if (sel == 5) begin
            if5.Data_Valid = dv; if5.P_DATA = d[4:0]; if5.PAR_TYP = pt;
            if5.busy = b; if5.ser_en = se; if5.mux_sel = ms;
        end else begin
            if8.Data_Valid = dv; if8.P_DATA = d; if8.PAR_TYP = pt;
            if8.busy = b; if8.ser_en = se; if8.mux_sel = ms;
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 5) ? if5.TX_OUT : if8.TX_OUT;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 5) ? if5.ser_done : if8.ser_done;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit period: drive FSM outputs, check comb ser_done, clock, check line.
    task automatic cyc(input int sel, input logic dv, input logic [7:0] d,
                       input logic pt, input logic b, input logic se,
                       input logic [1:0] ms, input logic exp_done,
                       input logic exp_tx, input string tag, output logic ds);
        set_in(sel, dv, d, pt, b, se, ms);
        #1;
        ds = done_of(sel);
        chk($sformatf("%s_done", tag), {31'd0, ds}, {31'd0, exp_done});
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s_tx", tag), {31'd0, tx_of(sel)}, {31'd0, exp_tx});
    endtask

    // Full frame. exp holds the line sequence, first bit at position n-1.
    // idle_load: load from idle first; junk_at: data index with a stray
    // Data_Valid of all-ones; stop_load: load nd/npt during STOP.
    task automatic frame(input int sel, input int w, input logic [7:0] d,
                         input logic pt, input logic pe, input logic [15:0] exp,
                         input string tag, input logic idle_load, input int junk_at,
                         input logic stop_load, input logic [7:0] nd, input logic npt);
        int   n;
        int   pulses;
        logic ds;
        logic jv;
        n = w + 2 + (pe ? 1 : 0);
        pulses = 0;
        if (idle_load)
            cyc(sel, 1'b1, d, pt, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, {tag, "_load"}, ds);
        cyc(sel, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, exp[n-1], {tag, "_start"}, ds);
        for (int i = 0; i < w; i++) begin
            jv = (i == junk_at);
            cyc(sel, jv, jv ? 8'hFF : 8'h00, jv, 1'b1, 1'b1, 2'b10, (i == w - 1),
                exp[n-2-i], $sformatf("%s_bit%0d", tag, i), ds);
            if (ds) pulses++;
        end
        if (pe)
            cyc(sel, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, exp[n-2-w], {tag, "_par"}, ds);
        cyc(sel, stop_load, nd, npt, 1'b1, 1'b0, 2'b01, 1'b0, exp[0], {tag, "_stop"}, ds);
        chk({tag, "_done_pulses"}, pulses, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic ds;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        set_in(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        set_in(5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset held with random inputs.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_in(8, 1'($urandom_range(1)), 8'($urandom_range(255)), 1'($urandom_range(1)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)));
            #1;
            chk("rst_tx", {31'd0, if8.TX_OUT}, 32'd1);
            chk("rst_done", {31'd0, if8.ser_done}, 32'd0);
        end

        // Release with busy low: line stays idle.
        @(negedge clk);
        set_in(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++)
            cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, "post_rst", ds);

        // A5 even parity: 0,1,0,1,0,0,1,0,1,0,1
        frame(8, 8, 8'hA5, 1'b0, 1'b1, 16'b0101_0010_101, "a5_even", 1'b1, -1, 1'b0, 8'h00, 1'b0);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "idle1", ds);

        // A5 odd parity: parity bit 1.
        frame(8, 8, 8'hA5, 1'b1, 1'b1, 16'b0101_0010_111, "a5_odd", 1'b1, -1, 1'b0, 8'h00, 1'b0);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "idle2", ds);

        // A5 without parity: 10-bit frame.
        frame(8, 8, 8'hA5, 1'b0, 1'b0, 16'b01_0100_1011, "a5_nopar", 1'b1, -1, 1'b0, 8'h00, 1'b0);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "idle3", ds);

        // Width 5, data 5'b10110, even parity 1: 0,0,1,1,0,1,1,1
        frame(5, 5, 8'h16, 1'b0, 1'b1, 16'b0011_0111, "w5", 1'b1, -1, 1'b0, 8'h00, 1'b0);
        cyc(5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "w5_idle", ds);

        // Back-to-back 0F then F0, second byte loaded in STOP.
        frame(8, 8, 8'h0F, 1'b0, 1'b1, 16'b011_1100_0001, "b2b_0f", 1'b1, -1, 1'b1, 8'hF0, 1'b0);
        frame(8, 8, 8'hF0, 1'b0, 1'b1, 16'b000_0011_1101, "b2b_f0", 1'b0, -1, 1'b0, 8'h00, 1'b0);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "idle4", ds);

        // Stray FF/odd load during serialization of 00 is ignored.
        frame(8, 8, 8'h00, 1'b0, 1'b1, 16'b000_0000_0001, "ignore", 1'b1, 2, 1'b0, 8'h00, 1'b0);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "idle5", ds);

        // Reset during data bit 3 of A5 (bits so far 1,0,1).
        cyc(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "mid_load", ds);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "mid_start", ds);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, "mid_bit0", ds);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, "mid_bit1", ds);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, "mid_bit2", ds);
        // Bit 2 (value 1) is on the line; drive bit 3 state then reset.
        set_in(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, if8.TX_OUT}, 32'd1);
        chk("mid_rst_done", {31'd0, if8.ser_done}, 32'd0);
        @(negedge clk);
        chk("mid_rst_hold_tx", {31'd0, if8.TX_OUT}, 32'd1);
        set_in(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "mid_idle", ds);

        // 3C after reset: 0,0,0,1,1,1,1,0,0,0,1
        frame(8, 8, 8'h3C, 1'b0, 1'b1, 16'b000_1111_0001, "after_rst", 1'b1, -1, 1'b0, 8'h00, 1'b0);
        cyc(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "final_idle", ds);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
